// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// The next_enabled helper serves the SCAN_MASK_EN build (channel skipping).
package mux_scan_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;
    localparam int CH_W  = SEL_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lowest enabled channel at or above 'from'; returns N_CH when none remain.
    function automatic logic [CH_W-1:0] next_enabled(
        input logic [N_CH-1:0] mask,
        input logic [CH_W-1:0] from
    );
        logic [CH_W-1:0] found;
        found = CH_W'(N_CH);
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                found = CH_W'(i);
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Loadable down-counter that sets how long each mux select is held.
// Load puts DWELL-1 in the counter; zero marks the last cycle of a dwell.
module dwell_timer #(
    parameter int DWELL = 1,
    localparam int CW   = $clog2(DWELL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    output logic [CW-1:0] count,
    output logic          zero
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps the 8:1 mux select, samples mux_out at the end of each dwell and
// presents a parallel byte with a valid pulse. Optional: SCAN_MASK_EN (ch_mask).
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mux_out,
`ifdef SCAN_MASK_EN
    input  logic [N_CH-1:0]              ch_mask,
`endif
    output logic [SEL_W-1:0]             sel,
    output logic                         busy,
    output logic [N_CH-1:0]              data_out,
    output logic                         valid,
    output state_t                       state,
    output logic [$clog2(DWELL+1)-1:0]   dwell_count
);

    state_t          state_next;
    logic            dwell_load;
    logic            dwell_zero;
    logic            last_ch;
    logic [CH_W-1:0] first_ch;
    logic [CH_W-1:0] next_ch;
    logic [N_CH-1:0] asm_q;
    logic [N_CH-1:0] asm_upd;

    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (dwell_load),
        .count (dwell_count),
        .zero  (dwell_zero)
    );

`ifdef SCAN_MASK_EN
    logic [N_CH-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if ((state == IDLE) && start) begin
            mask_q <= ch_mask;
        end
    end

    // first_ch uses the live mask because it is needed on the accept cycle itself.
    assign first_ch = next_enabled(ch_mask, '0);
    assign next_ch  = next_enabled(mask_q, {1'b0, sel} + CH_W'(1));
`else
    assign first_ch = '0;
    assign next_ch  = {1'b0, sel} + CH_W'(1);
`endif

    // A next channel equal to N_CH means the current one is the last of the sweep.
    assign last_ch = (next_ch == CH_W'(N_CH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (first_ch == CH_W'(N_CH)) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (dwell_zero && last_ch) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        valid        = (state == DONE);
        dwell_load   = 1'b0;
        asm_upd      = asm_q;
        asm_upd[sel] = mux_out;
        if ((state == IDLE) && start && (state_next == SCAN)) begin
            dwell_load = 1'b1;
        end
        if ((state == SCAN) && dwell_zero && !last_ch) begin
            dwell_load = 1'b1;
        end
    end

    // data_out is loaded on the SCAN->DONE edge so it lines up with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= '0;
            asm_q    <= '0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel   <= first_ch[SEL_W-1:0];
                        asm_q <= '0;
                        if (state_next == DONE) begin
                            data_out <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (dwell_zero) begin
                        asm_q <= asm_upd;
                        if (last_ch) begin
                            data_out <= asm_upd;
                        end else begin
                            sel <= next_ch[SEL_W-1:0];
                        end
                    end
                end
                DONE: begin
                    sel <= '0;
                end
                default: begin
                    sel <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer for the 8-to-1 mux stage, sitting both upstream and downstream of it. On `start` it drives the mux `sel` from 0 through 7 and holds each select value for a programmable dwell time. On the last dwell cycle of each channel it samples the mux `out`. After the sweep it presents the eight samples as one byte with a single-cycle `valid` pulse. This turns the 8 mux inputs into a periodic parallel snapshot for downstream logic.

## Interface
- `DWELL`, default 1: cycles `sel` is held per channel before sampling; legal range 1..255.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  sweep request; sampled only when `busy`=0.
- `mux_out`  input  1  the mux `out` for the current `sel`.
- `ch_mask`  input  8  per-channel enable; present only with `SCAN_MASK_EN`.
- `sel`  output  3  the mux select.
- `busy`  output  1  high from the cycle after `start` is accepted until the cycle `valid` is high (inclusive).
- `data_out`  output  8  bit i = sample taken with `sel`=i; held until the next `valid`.
- `valid`  output  1  one-cycle pulse when `data_out` is updated.

## Operation
- States:
  - IDLE: `busy`=0, `sel`=0.
  - SCAN: dwell counter running on the current channel.
  - DONE: one cycle; `data_out`, `valid`=1.
- IDLE -> SCAN on `start`=1. The next cycle has `sel`=first channel, the dwell counter loaded with DWELL-1, and the internal shift/assembly register cleared.
- In SCAN with counter≠0: decrement the counter; `sel` is unchanged.
- In SCAN with counter=0:
  - write `mux_out` into assembly bit `sel`.
  - If `sel` is the last channel, go to DONE.
  - Otherwise advance `sel` to the next channel and reload the counter.
- DONE -> IDLE unconditionally. `data_out` is loaded from the assembly register on the DONE transition, so it is visible in the same cycle `valid`=1.
- `start` while `busy`=1 or in DONE: ignored; it is not queued.
- `start` held high continuously: back-to-back sweeps, with one IDLE cycle between DONE and the next SCAN.
- `mux_out` is treated as stable; there is no synchroniser in this block.
- Reset values: `sel`=0, `busy`=0, `valid`=0, `data_out`=8'h00, state IDLE, counter 0.
- `rst` mid-sweep: same values next cycle; the partial sample is discarded and no `valid` is issued.

## Timing
- Cycle 0 is `start` accepted in IDLE. Channel i is selected for cycles 1+i·DWELL .. (i+1)·DWELL.
- Channel i is sampled at the end of cycle (i+1)·DWELL.
- `valid` is at cycle 8·DWELL+1; the earliest next accept is at cycle 8·DWELL+2.
- DWELL=1: `sel` changes every cycle and `valid` is at cycle 9.
- The dwell counter is $clog2(DWELL+1) bits wide. `sel` wraps only via IDLE, never from 7 to 0 within SCAN.

## Configuration
- `SCAN_MASK_EN` defined:
  - The `ch_mask` port exists and is captured at `start` accept.
  - Channels with a mask bit of 0 are skipped in zero cycles; their `data_out` bit is 0.
  - "First" and "last" channel refer to the lowest and highest enabled channel.
  - `ch_mask`=0: go directly to DONE (`valid` at cycle 1, `data_out`=0).
  - Latency is (enabled count)·DWELL+1.
- `SCAN_MASK_EN` undefined: no `ch_mask` port; all 8 channels are always scanned.

## Structure
- Shared package `mux_scan_pkg`:
  - state enum {IDLE, SCAN, DONE}.
  - constants N_CH=8 and SEL_W=3.
  - a next-enabled-channel function, used under the macro.
- One sub-module, `dwell_timer`: a loadable down-counter, parameterised by DWELL, with `load`, `zero` and counter outputs.
- The top instantiates `dwell_timer`. The mux is not part of this block; the bench instantiates the mux alongside.

## Test plan
- Reset then idle, with mux inputs in0..in7 = 1,0,0,0,1,1,0,1 -> `sel`=0, `busy`=0, `valid`=0, `data_out`=8'h00 indefinitely.
- Same inputs, DWELL=1, one `start` pulse -> `sel` steps 0..7 on cycles 1..8; `valid` on cycle 9 with `data_out`=8'hB1; `busy` high on cycles 1..9.
- DWELL=3, inputs all 1 -> each `sel` value held 3 cycles; `valid` on cycle 25 with `data_out`=8'hFF.
- `start` re-asserted on cycle 4 of a DWELL=1 sweep -> ignored; a single `valid` on cycle 9. `start` held high -> `valid` on cycles 9 and 19.
- `rst` on cycle 5 of a sweep -> cycle 6 shows `sel`=0, `busy`=0, `data_out`=8'h00; no `valid`.
- With `SCAN_MASK_EN`, `ch_mask`=8'b1000_0101, DWELL=1, the same inputs -> `sel` sequence 0, 2, 7; `valid` on cycle 4 with `data_out`=8'h81. With `ch_mask`=0 -> `valid` on cycle 1, `data_out`=8'h00.
